carpark_occupancy_fsm: RTL

//  Downstream consumer of the two-beam car-park sensor pair (a = outer beam, b = inner beam).

---
 rtl/carpark_pkg.sv | 17 +
 rtl/carpark_in_sync.sv | 26 ++
 rtl/carpark_occupancy_fsm.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/carpark_pkg.sv
// Shared types for the car-park occupancy decoder: fixed FSM encodings and default capacity.
package carpark_pkg;

    localparam int CAP_DEFAULT = 15;

    // Encodings are exposed on debug_state and must not be reordered.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EN1  = 3'd1,
        S_EN2  = 3'd2,
        S_EN3  = 3'd3,
        S_EX1  = 3'd4,
        S_EX2  = 3'd5,
        S_EX3  = 3'd6
    } state_t;

endpackage

// File: rtl/carpark_in_sync.sv
// Two-flop synchroniser for the beam inputs; both stages clear on synchronous reset.
module carpark_in_sync #(
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_meta;
    logic [DATA_W-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/carpark_occupancy_fsm.sv
// Two-beam entry/exit decoder with saturating occupancy count.
// Define CARPARK_IN_SYNC_EN to insert a 2-flop synchroniser on a/b (adds 2 cycles latency).
module carpark_occupancy_fsm
    import carpark_pkg::*;
#(
    parameter int CAP   = CAP_DEFAULT,
    parameter int CNT_W = $clog2(CAP + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    output logic [CNT_W-1:0] count,
    output logic [2:0]       debug_state,
    output logic             inc_pulse,
    output logic             dec_pulse,
    output logic             full,
    output logic             empty,
    output logic             seq_err
);

    logic [1:0]       w_ab;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_inc;
    logic             w_dec;
    logic             w_err;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_inc;
    logic             r_dec;
    logic             r_err;
    logic             r_full;
    logic             r_empty;

`ifdef CARPARK_IN_SYNC_EN
    carpark_in_sync #(.DATA_W(2)) u_in_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   ({a, b}),
        .o_q   (w_ab)
    );
`else
    assign w_ab = {a, b};
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_W'(CAP)) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    // Each state holds on its own ab code; every other code is listed explicitly.
    always_comb begin
        w_state_nxt = r_state;
        w_inc       = 1'b0;
        w_dec       = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: case (w_ab)
                2'b10:   w_state_nxt = S_EN1;
                2'b01:   w_state_nxt = S_EX1;
                2'b11:   w_err = 1'b1;
                default: w_state_nxt = S_IDLE;
            endcase
            S_EN1: case (w_ab)
                2'b11:   w_state_nxt = S_EN2;
                2'b00:   w_state_nxt = S_IDLE;
                2'b01:   begin w_state_nxt = S_IDLE; w_err = 1'b1; end
                default: w_state_nxt = S_EN1;
            endcase
            S_EN2: case (w_ab)
                2'b01:   w_state_nxt = S_EN3;
                2'b10:   w_state_nxt = S_EN1;
                2'b00:   begin w_state_nxt = S_IDLE; w_err = 1'b1; end
                default: w_state_nxt = S_EN2;
            endcase
            S_EN3: case (w_ab)
                2'b00:   begin w_state_nxt = S_IDLE; w_inc = 1'b1; end
                2'b11:   w_state_nxt = S_EN2;
                2'b10:   begin w_state_nxt = S_IDLE; w_err = 1'b1; end
                default: w_state_nxt = S_EN3;
            endcase
            S_EX1: case (w_ab)
                2'b11:   w_state_nxt = S_EX2;
                2'b00:   w_state_nxt = S_IDLE;
                2'b10:   begin w_state_nxt = S_IDLE; w_err = 1'b1; end
                default: w_state_nxt = S_EX1;
            endcase
            S_EX2: case (w_ab)
                2'b10:   w_state_nxt = S_EX3;
                2'b01:   w_state_nxt = S_EX1;
                2'b00:   begin w_state_nxt = S_IDLE; w_err = 1'b1; end
                default: w_state_nxt = S_EX2;
            endcase
            S_EX3: case (w_ab)
                2'b00:   begin w_state_nxt = S_IDLE; w_dec = 1'b1; end
                2'b11:   w_state_nxt = S_EX2;
                2'b01:   begin w_state_nxt = S_IDLE; w_err = 1'b1; end
                default: w_state_nxt = S_EX3;
            endcase
            default: begin
                w_state_nxt = S_IDLE;
                w_err       = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_inc) begin
            w_count_nxt = sat_inc(r_count);
        end else if (w_dec) begin
            w_count_nxt = sat_dec(r_count);
        end
    end

    // Flags derive from the next count so they line up with count in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            r_err   <= 1'b0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_inc   <= w_inc;
            r_dec   <= w_dec;
            r_err   <= w_err;
            r_full  <= (w_count_nxt == CNT_W'(CAP));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign count       = r_count;
    assign debug_state = r_state;
    assign inc_pulse   = r_inc;
    assign dec_pulse   = r_dec;
    assign seq_err     = r_err;
    assign full        = r_full;
    assign empty       = r_empty;

endmodule
